knight_anim: RTL and testbench
==============================

KNIGHT_ANIM -- requirements
Module: knight_anim

Interface
REQ-001 Parameter ANIM_DIV, default 6: frame_clk cycles per animation step, legal range 1..15.
REQ-002 Parameter HURT_FRAMES, default 60: length of the post-damage blink window in frame_clk cycles.
REQ-003 Port frame_clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 Port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port Player_Status, input, 4 bits: player motion code (0 idle, 1 walk, 2 jump, 3 fall, 4 attack).
REQ-006 Port Player_Life, input, 4 bits: remaining lives.
REQ-007 Port Inverse, input, 1 bit: facing direction (0 right, 1 left).
REQ-008 Port Anim_State, output, 3 bits: current FSM state code.
REQ-009 Port Anim_Frame, output, 5 bits: global sprite frame index, range 0..18.
REQ-010 Port Sprite_Base, output, 16 bits: sprite ROM word address of frame start, equal to Anim_Frame*1860.
REQ-011 Port Sprite_Mirror, output, 1 bit: horizontal flip request.
REQ-012 Port Sprite_Visible, output, 1 bit: draw enable.
REQ-013 Port Attack_Busy, output, 1 bit: high while the attack sequence plays.

Function
REQ-014 The FSM SHALL have states IDLE=0, WALK=1, JUMP=2, FALL=3, ATTACK=4, DEAD=5.
REQ-015 Each state SHALL map to a frame count and a base index: IDLE 4/0, WALK 6/4, JUMP 2/10, FALL 2/12, ATTACK 5/14, DEAD 1/13.
REQ-016 Anim_Frame SHALL equal base index + local frame.
REQ-017 All outputs SHALL be registered, with one frame_clk cycle of latency from input to output.
REQ-018 A step divider SHALL count 0..ANIM_DIV-1; the local frame advances only when the divider wraps.
REQ-019 IDLE and WALK SHALL loop their local frame back to 0.
REQ-020 JUMP and FALL SHALL hold their last local frame; they do not wrap.
REQ-021 Outside ATTACK and DEAD, a change of Player_Status SHALL move to the mapped state, with local frame and divider cleared in the same cycle.
REQ-022 Status codes 5..15 SHALL map to IDLE.
REQ-023 Entry to ATTACK SHALL be a one-shot: all 5 frames play regardless of Player_Status.
REQ-024 Attack_Busy SHALL be high throughout ATTACK.
REQ-025 Exit from ATTACK SHALL occur after the last frame has been held ANIM_DIV cycles, into the state mapped from the current status; if the status is still 4, the attack restarts at frame 0.
REQ-026 Sprite_Mirror SHALL follow Inverse every cycle, except in ATTACK, where it is frozen at its value when the attack was entered.
REQ-027 Player_Life==0 SHALL force DEAD from any state, with priority over attack completion.
REQ-028 DEAD SHALL output Anim_Frame=13 and Sprite_Visible=1, and SHALL be left only through Reset.
REQ-029 Sprite_Base SHALL be computed by constant multiply, truncation-free; the maximum is 18*1860=33480.

Reset
REQ-030 Reset SHALL force the following values: state IDLE, Anim_Frame 0, Sprite_Base 0, Sprite_Mirror 0, Sprite_Visible 1, Attack_Busy 0, divider 0, blink counter 0, registered previous life 5.
REQ-031 Reset asserted mid-attack SHALL abort the attack immediately and asynchronously.

Configuration
REQ-032 Macro KNIGHT_HURT_BLINK_EN defined: when Player_Life falls below the registered previous life and is nonzero, a counter SHALL load HURT_FRAMES.
REQ-033 Macro KNIGHT_HURT_BLINK_EN defined: while the counter is nonzero, Sprite_Visible SHALL equal bit 2 of the counter, and the counter SHALL decrement each cycle.
REQ-034 Macro KNIGHT_HURT_BLINK_EN defined: a further life decrease during the blink window SHALL reload the counter.
REQ-035 Macro KNIGHT_HURT_BLINK_EN undefined: Sprite_Visible SHALL be constant 1, and no life-history or blink logic SHALL be synthesised.

Structure
REQ-036 Package knight_pkg SHALL hold:
- the status codes;
- the anim state enum;
- the frame count and base index tables;
- FRAME_WORDS=1860;
- KNIGHT_LIFE=5.
REQ-037 The step divider SHALL be the sub-module anim_tick, with ports frame_clk, Reset, clr, and tick.

Verification
REQ-038 Scenario: with ANIM_DIV=6 and status held at 1 for 40 cycles -> Anim_Frame steps through 4,5,...,9 then back to 4, changing every 6 cycles.
REQ-039 Scenario: status=4 for 1 cycle, then 0 -> Attack_Busy stays high 30 cycles, Anim_Frame steps 14..18, then the block returns to IDLE with Anim_Frame 0.
REQ-040 Scenario: status=2 for 20 cycles -> Anim_Frame 10, then 11, and holds at 11.
REQ-041 Scenario: Inverse toggles mid-attack -> Sprite_Mirror unchanged until the attack ends, then follows Inverse.
REQ-042 Scenario: life goes 5 to 4 with the macro defined -> Sprite_Visible toggles every 4 cycles for 60 cycles, then stays 1.
REQ-043 Scenario: life goes to 0 during attack frame 16 -> DEAD next cycle, with Anim_Frame 13 and Attack_Busy 0.
REQ-044 Scenario: Reset pulse while in DEAD -> IDLE with Anim_Frame 0 and Sprite_Base 0.

Source files
------------

// File: rtl/knight_pkg.sv
// knight_pkg: shared definitions for the knight sprite animator.
//   - player status codes driven by the game logic
//   - animation state enum (values double as the Anim_State output code)
//   - per-state frame count and base sprite index tables
//   - FRAME_WORDS: sprite ROM words per frame; KNIGHT_LIFE: starting lives
package knight_pkg;

  localparam logic [3:0] STATUS_IDLE   = 4'd0;
  localparam logic [3:0] STATUS_WALK   = 4'd1;
  localparam logic [3:0] STATUS_JUMP   = 4'd2;
  localparam logic [3:0] STATUS_FALL   = 4'd3;
  localparam logic [3:0] STATUS_ATTACK = 4'd4;

  localparam int FRAME_WORDS = 1860;
  localparam int KNIGHT_LIFE = 5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WALK   = 3'd1,
    S_JUMP   = 3'd2,
    S_FALL   = 3'd3,
    S_ATTACK = 3'd4,
    S_DEAD   = 3'd5
  } anim_state_t;

  function automatic logic [2:0] frame_count(input anim_state_t s);
    case (s)
      S_IDLE:   return 3'd4;
      S_WALK:   return 3'd6;
      S_JUMP:   return 3'd2;
      S_FALL:   return 3'd2;
      S_ATTACK: return 3'd5;
      default:  return 3'd1;
    endcase
  endfunction

  function automatic logic [4:0] base_index(input anim_state_t s);
    case (s)
      S_IDLE:   return 5'd0;
      S_WALK:   return 5'd4;
      S_JUMP:   return 5'd10;
      S_FALL:   return 5'd12;
      S_ATTACK: return 5'd14;
      default:  return 5'd13;
    endcase
  endfunction

  // Unknown status codes fall back to IDLE so a glitching game FSM
  // never leaves the sprite in an undefined animation.
  function automatic anim_state_t status_to_state(input logic [3:0] code);
    case (code)
      STATUS_WALK:   return S_WALK;
      STATUS_JUMP:   return S_JUMP;
      STATUS_FALL:   return S_FALL;
      STATUS_ATTACK: return S_ATTACK;
      default:       return S_IDLE;
    endcase
  endfunction

  // Looping animations wrap to frame 0; the others hold their last frame.
  function automatic logic loops(input anim_state_t s);
    return (s == S_IDLE) || (s == S_WALK);
  endfunction

endpackage

// File: rtl/knight_anim_tick.sv
// anim_tick: animation step divider.
//   frame_clk : clock
//   Reset     : asynchronous active-high reset
//   clr       : restart the divider at 0 (state change)
//   tick      : high during the last divider cycle; the step happens on
//               the edge that ends this cycle
import knight_pkg::*;

module anim_tick #(
  parameter int ANIM_DIV = 6
) (
  input  logic frame_clk,
  input  logic Reset,
  input  logic clr,
  output logic tick
);

  logic [3:0] count;

  assign tick = (count == 4'(ANIM_DIV - 1));

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset)
      count <= '0;
    else if (clr || tick)
      count <= '0;
    else
      count <= count + 4'd1;
  end

endmodule

// File: rtl/knight_anim.sv
// knight_anim: sprite animation controller for the player knight.
//   frame_clk      : clock (one cycle per video frame)
//   Reset          : asynchronous active-high reset
//   Player_Status  : motion code 0 idle, 1 walk, 2 jump, 3 fall, 4 attack
//   Player_Life    : remaining lives; 0 forces the DEAD pose
//   Inverse        : facing direction (1 = left)
//   Anim_State     : current animation state code
//   Anim_Frame     : global sprite frame index 0..18
//   Sprite_Base    : sprite ROM word address of the frame (Anim_Frame*1860)
//   Sprite_Mirror  : horizontal flip request
//   Sprite_Visible : draw enable
//   Attack_Busy    : high while the attack animation plays
// Optional feature: define KNIGHT_HURT_BLINK_EN to blink the sprite for
// HURT_FRAMES cycles after each lost life.
import knight_pkg::*;

module knight_anim #(
  parameter int ANIM_DIV    = 6,
  parameter int HURT_FRAMES = 60
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [3:0]  Player_Status,
  input  logic [3:0]  Player_Life,
  input  logic        Inverse,
  output logic [2:0]  Anim_State,
  output logic [4:0]  Anim_Frame,
  output logic [15:0] Sprite_Base,
  output logic        Sprite_Mirror,
  output logic        Sprite_Visible,
  output logic        Attack_Busy
);

  anim_state_t state, state_n, target;
  logic [2:0]  lf, lf_n;
  logic        clr, tick, enter_atk, last;
  logic [4:0]  frame_n;
  logic [15:0] base_n;
  logic        mirror_n;

  anim_tick #(.ANIM_DIV(ANIM_DIV)) u_tick (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .clr       (clr),
    .tick      (tick)
  );

  // State register
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      lf    <= '0;
    end else begin
      state <= state_n;
      lf    <= lf_n;
    end
  end

  // Next-state logic
  always_comb begin
    target    = status_to_state(Player_Status);
    last      = (lf == frame_count(state) - 3'd1);
    state_n   = state;
    lf_n      = lf;
    clr       = 1'b0;
    enter_atk = 1'b0;
    if (Player_Life == 4'd0) begin
      // Death overrides everything, including a finishing attack.
      state_n = S_DEAD;
      lf_n    = '0;
      clr     = 1'b1;
    end else begin
      case (state)
        S_DEAD: ;
        S_ATTACK: begin
          if (tick) begin
            if (last) begin
              // Status is ignored during the attack and only sampled here;
              // a held attack status restarts a fresh attack.
              state_n   = target;
              lf_n      = '0;
              clr       = 1'b1;
              enter_atk = (target == S_ATTACK);
            end else begin
              lf_n = lf + 3'd1;
            end
          end
        end
        default: begin
          if (target != state) begin
            state_n   = target;
            lf_n      = '0;
            clr       = 1'b1;
            enter_atk = (target == S_ATTACK);
          end else if (tick) begin
            if (!last)
              lf_n = lf + 3'd1;
            else if (loops(state))
              lf_n = '0;
          end
        end
      endcase
    end
  end

  // Output logic: computed from the next state so the registered outputs
  // reflect the inputs one cycle later.
  always_comb begin
    frame_n  = base_index(state_n) + {2'b00, lf_n};
    base_n   = 16'(frame_n) * 16'(FRAME_WORDS);
    mirror_n = (state_n == S_ATTACK && !enter_atk) ? Sprite_Mirror : Inverse;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      Anim_Frame    <= '0;
      Sprite_Base   <= '0;
      Sprite_Mirror <= 1'b0;
      Attack_Busy   <= 1'b0;
    end else begin
      Anim_Frame    <= frame_n;
      Sprite_Base   <= base_n;
      Sprite_Mirror <= mirror_n;
      Attack_Busy   <= (state_n == S_ATTACK);
    end
  end

  assign Anim_State = state;

`ifdef KNIGHT_HURT_BLINK_EN
  localparam int BW = (HURT_FRAMES > 7) ? $clog2(HURT_FRAMES + 1) : 3;

  logic [BW-1:0] blink, blink_n;
  logic [3:0]    prev_life;
  logic          hurt, visible_n;

  always_comb begin
    hurt = (Player_Life < prev_life) && (Player_Life != 4'd0);
    if (hurt)
      blink_n = BW'(HURT_FRAMES);
    else if (blink != '0)
      blink_n = blink - BW'(1);
    else
      blink_n = blink;
    // DEAD pose is always drawn; otherwise bit 2 gives a 4-cycle blink.
    if (state_n == S_DEAD)
      visible_n = 1'b1;
    else if (blink_n != '0)
      visible_n = blink_n[2];
    else
      visible_n = 1'b1;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      blink          <= '0;
      prev_life      <= 4'(KNIGHT_LIFE);
      Sprite_Visible <= 1'b1;
    end else begin
      blink          <= blink_n;
      prev_life      <= Player_Life;
      Sprite_Visible <= visible_n;
    end
  end
`else
  assign Sprite_Visible = 1'b1;
`endif

endmodule

// File: tb/tb_knight_anim.sv
module tb_knight_anim;

  localparam int ANIM_DIV    = 6;
  localparam int HURT_FRAMES = 60;

  logic        frame_clk = 1'b0;
  logic        Reset = 1'b0;
  logic [3:0]  Player_Status = 4'd0;
  logic [3:0]  Player_Life = 4'd5;
  logic        Inverse = 1'b0;
  logic [2:0]  Anim_State;
  logic [4:0]  Anim_Frame;
  logic [15:0] Sprite_Base;
  logic        Sprite_Mirror;
  logic        Sprite_Visible;
  logic        Attack_Busy;

  knight_anim #(.ANIM_DIV(ANIM_DIV), .HURT_FRAMES(HURT_FRAMES)) dut (
    .frame_clk      (frame_clk),
    .Reset          (Reset),
    .Player_Status  (Player_Status),
    .Player_Life    (Player_Life),
    .Inverse        (Inverse),
    .Anim_State     (Anim_State),
    .Anim_Frame     (Anim_Frame),
    .Sprite_Base    (Sprite_Base),
    .Sprite_Mirror  (Sprite_Mirror),
    .Sprite_Visible (Sprite_Visible),
    .Attack_Busy    (Attack_Busy)
  );

  always #5 frame_clk = ~frame_clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks the state and the number of cycles spent in it
  // since entry; the frame is derived from elapsed time arithmetically.
  int m_state, m_t, m_mir, m_hcnt, m_prev;
  int cnt_tab[6]  = '{4, 6, 2, 2, 5, 1};
  int base_tab[6] = '{0, 4, 10, 12, 14, 13};

  function automatic int map_st(input int s);
    return (s >= 0 && s <= 4) ? s : 0;
  endfunction

  function automatic int m_frame();
    int k;
    if (m_state == 5) return 13;
    k = m_t / ANIM_DIV;
    if (m_state <= 1) k = k % cnt_tab[m_state];
    else if (k > cnt_tab[m_state] - 1) k = cnt_tab[m_state] - 1;
    return base_tab[m_state] + k;
  endfunction

  function automatic int m_vis();
`ifdef KNIGHT_HURT_BLINK_EN
    if (m_state == 5) return 1;
    if (m_hcnt > 0) return (m_hcnt >> 2) & 1;
    return 1;
`else
    return 1;
`endif
  endfunction

  task automatic m_enter(input int s, input int inv);
    m_state = s;
    m_t = 0;
    if (s == 4) m_mir = inv;
  endtask

  task automatic m_reset();
    m_state = 0; m_t = 0; m_mir = 0; m_hcnt = 0; m_prev = 5;
  endtask

  task automatic m_step(input int st, input int li, input int inv);
    if (li == 0) begin
      m_state = 5; m_t = 0;
    end else if (m_state == 5) begin
      m_t = 0;
    end else if (m_state == 4) begin
      m_t++;
      if (m_t == 5 * ANIM_DIV) m_enter(map_st(st), inv);
    end else if (map_st(st) != m_state) begin
      m_enter(map_st(st), inv);
    end else begin
      m_t++;
    end
    if (m_state != 4) m_mir = inv;
    if (li < m_prev && li != 0) m_hcnt = HURT_FRAMES;
    else if (m_hcnt > 0) m_hcnt--;
    m_prev = li;
  endtask

  task automatic check_model();
    chk("state",   32'(Anim_State),     m_state);
    chk("frame",   32'(Anim_Frame),     m_frame());
    chk("base",    32'(Sprite_Base),    m_frame() * 1860);
    chk("mirror",  32'(Sprite_Mirror),  m_mir);
    chk("visible", 32'(Sprite_Visible), m_vis());
    chk("busy",    32'(Attack_Busy),    (m_state == 4) ? 1 : 0);
  endtask

  // Called at posedge+1 or later; drives inputs, clocks once, checks.
  task automatic step(input int st, input int li, input int inv);
    Player_Status = 4'(st);
    Player_Life   = 4'(li);
    Inverse       = inv[0];
    @(posedge frame_clk);
    m_step(st, li, inv);
    #1;
    check_model();
  endtask

  // Asserts Reset between clock edges; outputs must clear without a clock.
  task automatic reset_pulse(input string nm);
    #2;
    Reset = 1'b1;
    m_reset();
    #1;
    chk({nm, "_state"},   32'(Anim_State),     0);
    chk({nm, "_frame"},   32'(Anim_Frame),     0);
    chk({nm, "_base"},    32'(Sprite_Base),    0);
    chk({nm, "_mirror"},  32'(Sprite_Mirror),  0);
    chk({nm, "_visible"}, 32'(Sprite_Visible), 1);
    chk({nm, "_busy"},    32'(Attack_Busy),    0);
    @(posedge frame_clk);
    #2;
    Reset = 1'b0;
  endtask

  typedef struct {
    int st; int li; int inv; int n;
    int e_state; int e_frame; int e_busy; int e_mir;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int busy_cnt, life, hold, st, inv, dead_cyc;

    tbl[0]  = '{1, 5, 0, 1,  1, 4,  0, 0};  // enter WALK
    tbl[1]  = '{1, 5, 0, 5,  1, 4,  0, 0};  // first frame held 6 cycles
    tbl[2]  = '{1, 5, 0, 1,  1, 5,  0, 0};  // advance
    tbl[3]  = '{1, 5, 0, 30, 1, 4,  0, 0};  // wrapped back to 4
    tbl[4]  = '{2, 5, 0, 1,  2, 10, 0, 0};  // JUMP
    tbl[5]  = '{2, 5, 0, 6,  2, 11, 0, 0};
    tbl[6]  = '{2, 5, 0, 13, 2, 11, 0, 0};  // holds last frame
    tbl[7]  = '{3, 5, 1, 1,  3, 12, 0, 1};  // FALL, mirror follows
    tbl[8]  = '{9, 5, 0, 1,  0, 0,  0, 0};  // unknown code -> IDLE
    tbl[9]  = '{4, 5, 1, 1,  4, 14, 1, 1};  // attack entry
    tbl[10] = '{0, 5, 0, 12, 4, 16, 1, 1};  // one-shot, mirror frozen
    tbl[11] = '{0, 5, 0, 17, 4, 18, 1, 1};
    tbl[12] = '{0, 5, 0, 1,  0, 0,  0, 0};  // back to IDLE

    reset_pulse("reset");
    for (int i = 0; i < 13; i++) begin
      for (int j = 0; j < tbl[i].n; j++) step(tbl[i].st, tbl[i].li, tbl[i].inv);
      chk($sformatf("tbl%0d_state", i), 32'(Anim_State),    tbl[i].e_state);
      chk($sformatf("tbl%0d_frame", i), 32'(Anim_Frame),    tbl[i].e_frame);
      chk($sformatf("tbl%0d_base", i),  32'(Sprite_Base),   tbl[i].e_frame * 1860);
      chk($sformatf("tbl%0d_busy", i),  32'(Attack_Busy),   tbl[i].e_busy);
      chk($sformatf("tbl%0d_mir", i),   32'(Sprite_Mirror), tbl[i].e_mir);
    end

    // Attack pulse of one cycle plays the full 30-cycle sequence.
    reset_pulse("rst_atk");
    step(4, 5, 0);
    busy_cnt = Attack_Busy ? 1 : 0;
    for (int i = 0; i < 60; i++) begin
      step(0, 5, 0);
      if (Attack_Busy) busy_cnt++;
      else break;
    end
    chk("attack_busy_len", busy_cnt, 30);
    chk("attack_end_frame", 32'(Anim_Frame), 0);
    chk("attack_end_state", 32'(Anim_State), 0);

    // Mirror frozen through the attack, follows Inverse afterwards.
    step(4, 5, 0);
    for (int i = 0; i < 29; i++) step(0, 5, 1);
    chk("mirror_frozen", 32'(Sprite_Mirror), 0);
    step(0, 5, 1);
    chk("mirror_release", 32'(Sprite_Mirror), 1);

    // Held attack status restarts the attack at frame 14.
    step(4, 5, 0);
    for (int i = 0; i < 30; i++) step(4, 5, 0);
    chk("attack_restart_frame", 32'(Anim_Frame), 14);
    chk("attack_restart_busy", 32'(Attack_Busy), 1);

    // Asynchronous reset mid-attack.
    reset_pulse("rst_mid_attack");

    // Death during attack frame 16.
    step(4, 5, 0);
    for (int i = 0; i < 12; i++) step(0, 5, 0);
    chk("pre_death_frame", 32'(Anim_Frame), 16);
    step(0, 0, 0);
    chk("dead_state", 32'(Anim_State), 5);
    chk("dead_frame", 32'(Anim_Frame), 13);
    chk("dead_busy",  32'(Attack_Busy), 0);
    for (int i = 0; i < 5; i++) step(1, 3, 0);
    chk("dead_sticky", 32'(Anim_State), 5);
    chk("dead_visible", 32'(Sprite_Visible), 1);
    reset_pulse("rst_dead");

    // Lost life: blink window (only blinks when the feature is built in).
    for (int i = 0; i < 70; i++) step(0, 4, 0);
    chk("blink_over_visible", 32'(Sprite_Visible), 1);
    reset_pulse("rst_rand");

    // Randomized run against the model.
    life = 5; hold = 0; st = 0; inv = 0; dead_cyc = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        st = $urandom_range(0, 4);
        hold = $urandom_range(1, 40);
      end
      hold--;
      if ($urandom_range(0, 7) == 0) inv = 1 - inv;
      if ($urandom_range(0, 59) == 0 && life > 0) life--;
      else if ($urandom_range(0, 89) == 0 && life > 0 && life < 15) life++;
      step(st, life, inv);
      if (life == 0) begin
        dead_cyc++;
        if (dead_cyc > 5) begin
          reset_pulse("rst_rand_dead");
          life = 5;
          dead_cyc = 0;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule
